// File: rtl/io_target_regs_if.sv
// Wishbone-classic bus bundle between the I/O bridge master port and a register target.
// The bridge side uses the master modport and the responder uses the slave modport.
interface io_target_regs_if;
  logic        s_cyc_i;
  logic        s_stb_i;
  logic        s_we_i;
  logic [3:0]  s_sel_i;
  logic [31:0] s_adr_i;
  logic [31:0] s_dat_i;
  logic        s_ack_o;
  logic [31:0] s_dat_o;

  modport slave (
    input  s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i,
    output s_ack_o, s_dat_o
  );

  modport master (
    output s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i,
    input  s_ack_o, s_dat_o
  );
endinterface

// File: rtl/io_target_regs.sv
// Wishbone-classic I/O responder for one 64 KB window: scratch registers, ID, access counter
// with compare interrupt. Programmable wait states; ack is held until the initiator drops strobe.
//
// state   | meaning
// ST_IDLE | waiting for a request that hits the window
// ST_WAIT | request latched, counting down wait states
// ST_ACK  | ack and read data held until strobe drops
module io_target_regs #(
  parameter logic [31:0] BASE_ADR    = 32'hFD0C_0000,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VAL      = 32'h10C0_0001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  io_target_regs_if.slave  bus,
  output logic             irq_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t      state, state_nx;
  logic        req, hit, latch, enter_ack, leave_ack, dec;
  logic        we_q;
  logic [3:0]  sel_q, wcnt;
  logic [13:0] off_q;
  logic [31:0] dat_q;
  logic        c_we;
  logic [3:0]  c_sel;
  logic [13:0] c_off;
  logic [31:0] c_dat, rdata;
  logic [31:0] scr [8];
  logic [31:0] acnt, cmp;
  logic        pend, en;
  logic        wr, wr_scr, wr_acnt, wr_irq, wr_cmp, cmp_hit;
  logic        unused_adr;

  assign req        = bus.s_cyc_i & bus.s_stb_i;
  assign hit        = bus.s_adr_i[31:16] == BASE_ADR[31:16];
  assign unused_adr = ^bus.s_adr_i[1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    latch     = 1'b0;
    enter_ack = 1'b0;
    leave_ack = 1'b0;
    dec       = 1'b0;
    case (state)
      ST_IDLE: if (req && hit) begin
        latch = 1'b1;
        if (WS == 4'd0) begin
          state_nx  = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_nx = ST_IDLE;
        end else if (wcnt == 4'd1) begin
          state_nx  = ST_ACK;
          enter_ack = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      ST_ACK: if (!bus.s_stb_i) begin
        state_nx  = ST_IDLE;
        leave_ack = 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // With zero wait states the commit happens on the latch edge, so take the live bus values.
  always_comb begin
    if (state == ST_IDLE) begin
      c_we  = bus.s_we_i;
      c_sel = bus.s_sel_i;
      c_off = bus.s_adr_i[15:2];
      c_dat = bus.s_dat_i;
    end else begin
      c_we  = we_q;
      c_sel = sel_q;
      c_off = off_q;
      c_dat = dat_q;
    end
  end

  assign wr      = enter_ack & c_we;
  assign wr_scr  = wr && (c_off < 14'd8);
  assign wr_acnt = wr && (c_off == 14'd9);
  assign wr_irq  = wr && (c_off == 14'd10);
  assign wr_cmp  = wr && (c_off == 14'd11);
  assign cmp_hit = enter_ack && !wr_acnt && (cmp != 32'd0) && (acnt + 32'd1 == cmp);

  always_comb begin
    rdata = 32'd0;
    if (c_off < 14'd8) rdata = scr[c_off[2:0]];
    else if (c_off == 14'd8)  rdata = ID_VAL;
    else if (c_off == 14'd9)  rdata = acnt;
    else if (c_off == 14'd10) rdata = {30'd0, en, pend};
    else if (c_off == 14'd11) rdata = cmp;
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) v[8*b +: 8] = dat[8*b +: 8];
    return v;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q  <= 1'b0;
      sel_q <= 4'd0;
      off_q <= 14'd0;
      dat_q <= 32'd0;
      wcnt  <= 4'd0;
    end else if (latch) begin
      we_q  <= bus.s_we_i;
      sel_q <= bus.s_sel_i;
      off_q <= bus.s_adr_i[15:2];
      dat_q <= bus.s_dat_i;
      wcnt  <= WS;
    end else if (dec) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.s_ack_o <= 1'b0;
      bus.s_dat_o <= 32'd0;
    end else if (enter_ack) begin
      bus.s_ack_o <= 1'b1;
      bus.s_dat_o <= c_we ? 32'd0 : rdata;
    end else if (leave_ack) begin
      bus.s_ack_o <= 1'b0;
      bus.s_dat_o <= 32'd0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) scr[i] <= 32'd0;
      acnt  <= 32'd0;
      cmp   <= 32'd0;
      pend  <= 1'b0;
      en    <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_scr) scr[c_off[2:0]] <= merge(scr[c_off[2:0]], c_dat, c_sel);
      if (wr_cmp) cmp <= merge(cmp, c_dat, c_sel);
      if (wr_acnt)        acnt <= 32'd0;
      else if (enter_ack) acnt <= acnt + 32'd1;
      // A compare hit beats a simultaneous write-1-to-clear.
      if (cmp_hit) pend <= 1'b1;
      else if (wr_irq && c_sel[0] && c_dat[0]) pend <= 1'b0;
      if (wr_irq && c_sel[0]) en <= c_dat[1];
      irq_o <= pend & en;
    end
  end

endmodule

// File: tb/tb_io_target_regs.sv
// Bench for io_target_regs: directed and random Wishbone accesses checked against a
// register-level reference model of the window.
module tb_io_target_regs;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_target_regs_if bus_a ();
  io_target_regs_if bus_b ();
  logic irq_a, irq_b;

  io_target_regs #(.WAIT_STATES(1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a.slave), .irq_o(irq_a));
  io_target_regs #(.WAIT_STATES(3)) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b.slave), .irq_o(irq_b));

  logic        cyc = 0, stb = 0, we = 0, use_b = 0;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, dat = 0;

  assign bus_a.s_cyc_i = cyc & ~use_b;
  assign bus_a.s_stb_i = stb & ~use_b;
  assign bus_a.s_we_i  = we;
  assign bus_a.s_sel_i = sel;
  assign bus_a.s_adr_i = adr;
  assign bus_a.s_dat_i = dat;
  assign bus_b.s_cyc_i = cyc & use_b;
  assign bus_b.s_stb_i = stb & use_b;
  assign bus_b.s_we_i  = we;
  assign bus_b.s_sel_i = sel;
  assign bus_b.s_adr_i = adr;
  assign bus_b.s_dat_i = dat;

  wire        ack_m = use_b ? bus_b.s_ack_o : bus_a.s_ack_o;
  wire [31:0] dat_m = use_b ? bus_b.s_dat_o : bus_a.s_dat_o;
  wire        irq_m = use_b ? irq_b : irq_a;

  int total = 0;
  int bad   = 0;

  // Reference model of the window as seen through completed accesses.
  logic [31:0] m_scr [8];
  logic [31:0] m_acnt, m_cmp;
  bit          m_pend, m_en;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_scr[i] = 0;
    m_acnt = 0; m_cmp = 0; m_pend = 0; m_en = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [15:0] off);
    if (off < 16'h20)       return m_scr[off[4:2]];
    else if (off == 16'h20) return 32'h10C0_0001;
    else if (off == 16'h24) return m_acnt;
    else if (off == 16'h28) return {30'd0, m_en, m_pend};
    else if (off == 16'h2C) return m_cmp;
    return 32'd0;
  endfunction

  function automatic logic [31:0] bytes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  task automatic m_access(input bit w, input logic [15:0] off, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd);
    bit hit_cmp;
    rd = m_read(off);
    hit_cmp = 0;
    if (w && off == 16'h24) m_acnt = 0;
    else begin
      m_acnt = m_acnt + 1;
      hit_cmp = (m_cmp != 0) && (m_acnt == m_cmp);
    end
    if (w) begin
      if (off < 16'h20) m_scr[off[4:2]] = bytes(m_scr[off[4:2]], d, s);
      else if (off == 16'h2C) m_cmp = bytes(m_cmp, d, s);
      else if (off == 16'h28 && s[0]) begin
        if (d[0]) m_pend = 0;
        m_en = d[1];
      end
    end
    if (hit_cmp) m_pend = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic irq_at_ack, irq_at_hold;

  task automatic acc(input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input bit exp_ack, output logic [31:0] rd);
    int  n;
    bit  got;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; sel = s; dat = d;
    got = 0; n = 0; rd = 0;
    while (!got && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (ack_m) got = 1;
    end
    chk("ack_seen", 32'(got), 32'(exp_ack));
    if (got) begin
      chk("latency", 32'(n), use_b ? 32'd4 : 32'd2);
      rd = dat_m;
      irq_at_ack = irq_m;
      @(posedge clk); #1;
      chk("ack_hold", 32'(ack_m), 32'd1);
      chk("dat_hold", dat_m, rd);
      irq_at_hold = irq_m;
    end
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_fall", 32'(ack_m), 32'd0);
    chk("dat_zero", dat_m, 32'd0);
  endtask

  task automatic macc(input bit w, input logic [15:0] off, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp;
    m_access(w, off, s, d, exp);
    acc(w, {16'hFD0C, off}, s, d, 1'b1, rd);
    if (!w) chk("rdata", rd, exp);
    chk("irq", 32'(irq_a), 32'(m_pend & m_en));
  endtask

  logic [31:0] rd;
  bit          seen;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    m_reset();
    #22;
    chk("rst_ack", 32'(bus_a.s_ack_o), 32'd0);
    chk("rst_dat", bus_a.s_dat_o, 32'd0);
    chk("rst_irq", 32'(irq_a), 32'd0);
    @(negedge clk); rst = 0;

    macc(1, 16'h0C, 4'hF, 32'hDEADBEEF, rd);
    macc(0, 16'h0C, 4'hF, 32'h0, rd);
    chk("scr3", rd, 32'hDEADBEEF);

    macc(1, 16'h00, 4'hF, 32'hFFFFFFFF, rd);
    macc(1, 16'h00, 4'b0101, 32'h11223344, rd);
    macc(0, 16'h00, 4'hF, 32'h0, rd);
    chk("scr0_lanes", rd, 32'hFF22FF44);

    macc(0, 16'h20, 4'hF, 32'h0, rd);
    chk("id", rd, 32'h10C00001);

    macc(1, 16'h24, 4'hF, 32'h0, rd);
    for (int i = 0; i < 3; i++) begin
      macc(0, 16'h24, 4'hF, 32'h0, rd);
      chk("acnt_seq", rd, 32'(i));
    end
    macc(1, 16'h24, 4'hF, 32'h1234, rd);
    macc(0, 16'h24, 4'hF, 32'h0, rd);
    chk("acnt_clr", rd, 32'd0);

    macc(1, 16'h2C, 4'hF, 32'd5, rd);
    macc(1, 16'h28, 4'h1, 32'h2, rd);
    macc(1, 16'h24, 4'hF, 32'h0, rd);
    for (int i = 0; i < 4; i++) macc(0, 16'h04, 4'hF, 32'h0, rd);
    chk("irq_pre", 32'(irq_a), 32'd0);
    macc(0, 16'h08, 4'hF, 32'h0, rd);
    chk("irq_at_ack", 32'(irq_at_ack), 32'd0);
    chk("irq_rise", 32'(irq_at_hold), 32'd1);
    macc(1, 16'h28, 4'h1, 32'h3, rd);
    chk("irq_w1c", 32'(irq_a), 32'd0);

    macc(1, 16'h24, 4'hF, 32'h0, rd);
    for (int i = 0; i < 4; i++) macc(0, 16'h10, 4'hF, 32'h0, rd);
    macc(1, 16'h28, 4'h1, 32'h3, rd);
    macc(0, 16'h28, 4'hF, 32'h0, rd);
    chk("set_wins", rd, 32'h3);
    macc(1, 16'h28, 4'h1, 32'h1, rd);

    acc(0, 32'hFD0D0000, 4'hF, 32'h0, 1'b0, rd);
    macc(0, 16'h24, 4'hF, 32'h0, rd);
    macc(1, 16'h40, 4'hF, 32'hCAFEF00D, rd);
    macc(0, 16'h40, 4'hF, 32'h0, rd);
    chk("hole_zero", rd, 32'd0);

    for (int i = 0; i < 60; i++) begin
      int          k;
      logic [15:0] off;
      k = $urandom_range(0, 14);
      off = (k < 12) ? 16'(k * 4) : (k == 12) ? 16'h30 : (k == 13) ? 16'h40 : 16'hFFFC;
      macc(1'($urandom_range(0, 1)), off, 4'($urandom), $urandom, rd);
    end

    use_b = 1;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'hFD0C0004; sel = 4'hF; dat = 32'hAAAA5555;
    @(posedge clk); #1; seen = ack_m;
    @(posedge clk); #1; seen = seen | ack_m;
    @(negedge clk); cyc = 0; stb = 0; we = 0;
    repeat (6) begin @(posedge clk); #1; seen = seen | ack_m; end
    chk("abort_noack", 32'(seen), 32'd0);
    acc(0, 32'hFD0C0004, 4'hF, 32'h0, 1'b1, rd);
    chk("abort_scr1", rd, 32'd0);
    acc(0, 32'hFD0C0024, 4'hF, 32'h0, 1'b1, rd);
    chk("abort_acnt", rd, 32'd1);
    use_b = 0;

    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'hFD0C0008; sel = 4'hF; dat = 32'h12345678;
    seen = 0;
    for (int n = 0; n < 10 && !seen; n++) begin @(posedge clk); #1; seen = ack_m; end
    chk("rst_pre_ack", 32'(seen), 32'd1);
    #2 rst = 1;
    #1;
    chk("rst_async_ack", 32'(bus_a.s_ack_o), 32'd0);
    chk("rst_async_dat", bus_a.s_dat_o, 32'd0);
    cyc = 0; stb = 0; we = 0;
    @(negedge clk); rst = 0;
    m_reset();
    for (int i = 0; i < 12; i++) macc(0, 16'(i * 4), 4'hF, 32'h0, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
